// File: rtl/cv32e40p_fpu_pkg.sv
// rtl/cv32e40p_fpu_pkg.sv - FPU request types, operation groups and legality helpers
package cv32e40p_fpu_pkg;

  localparam int OP_BITS         = 4;
  localparam int FP_FORMAT_BITS  = 3;
  localparam int INT_FORMAT_BITS = 2;
  localparam int NUM_FP_FORMATS  = 5;
  localparam int NUM_OPGROUPS    = 4;

  typedef enum logic [OP_BITS-1:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX, CMP, CLASSIFY,
    F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [FP_FORMAT_BITS-1:0] {
    FP32, FP64, FP16, FP8, FP16ALT
  } fp_format_e;

  typedef enum logic [INT_FORMAT_BITS-1:0] {
    INT8, INT16, INT32, INT64
  } int_format_e;

  typedef enum logic [1:0] {
    ADDMUL, DIVSQRT, NONCOMP, CONV
  } opgroup_e;

  typedef enum logic [2:0] {
    RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100, DYN = 3'b111
  } roundmode_e;

  // Fields are kept as raw vectors so out-of-range encodings survive queuing unchanged.
  typedef struct packed {
    logic                       illegal;
    logic [OP_BITS-1:0]         op;
    logic                       op_mod;
    logic [FP_FORMAT_BITS-1:0]  src_fmt;
    logic [FP_FORMAT_BITS-1:0]  dst_fmt;
    logic [INT_FORMAT_BITS-1:0] int_fmt;
    logic [2:0]                 rnd;
  } fpu_req_t;

  // Unknown operation encodings fall into CONV.
  function automatic opgroup_e get_opgroup(operation_e op);
    case (op)
      FMADD, FNMSUB, ADD, MUL:     return ADDMUL;
      DIV, SQRT:                   return DIVSQRT;
      SGNJ, MINMAX, CMP, CLASSIFY: return NONCOMP;
      default:                     return CONV;
    endcase
  endfunction

  // A format is usable only if it is a defined encoding and enabled in the mask.
  function automatic logic fmt_enabled(logic [FP_FORMAT_BITS-1:0] fmt,
                                       logic [NUM_FP_FORMATS-1:0] mask);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_FP_FORMATS; i++) begin
      if (fmt == FP_FORMAT_BITS'(i)) ok = mask[i];
    end
    return ok;
  endfunction

  function automatic logic req_illegal(logic [OP_BITS-1:0]        op,
                                       logic [FP_FORMAT_BITS-1:0] src_fmt,
                                       logic [FP_FORMAT_BITS-1:0] dst_fmt,
                                       logic [NUM_FP_FORMATS-1:0] mask);
    return (op > OP_BITS'(CPKCD)) | !fmt_enabled(src_fmt, mask) | !fmt_enabled(dst_fmt, mask);
  endfunction

endpackage

// File: rtl/cv32e40p_fpu_req_queue.sv
// rtl/cv32e40p_fpu_req_queue.sv - in-order tagged FP request buffer with legality and group tracking
module cv32e40p_fpu_req_queue
  import cv32e40p_fpu_pkg::*;
#(
  parameter int unsigned               DEPTH        = 4,
  parameter int unsigned               FLEN         = 32,
  parameter int unsigned               TAG_WIDTH    = 5,
  parameter logic [NUM_FP_FORMATS-1:0] FP_FMT_MASK  = 5'b00001,
  parameter bit                        FALL_THROUGH = 1'b0,
  localparam int unsigned              CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [OP_BITS-1:0]         in_op_i,
  input  logic                       in_op_mod_i,
  input  logic [FP_FORMAT_BITS-1:0]  in_src_fmt_i,
  input  logic [FP_FORMAT_BITS-1:0]  in_dst_fmt_i,
  input  logic [INT_FORMAT_BITS-1:0] in_int_fmt_i,
  input  logic [2:0]                 in_rnd_i,
  input  logic [3*FLEN-1:0]          in_operands_i,
  input  logic [TAG_WIDTH-1:0]       in_tag_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [OP_BITS-1:0]         out_op_o,
  output logic                       out_op_mod_o,
  output logic [FP_FORMAT_BITS-1:0]  out_src_fmt_o,
  output logic [FP_FORMAT_BITS-1:0]  out_dst_fmt_o,
  output logic [INT_FORMAT_BITS-1:0] out_int_fmt_o,
  output logic [2:0]                 out_rnd_o,
  output logic [3*FLEN-1:0]          out_operands_o,
  output logic [TAG_WIDTH-1:0]       out_tag_o,
  output logic                       out_illegal_o,
  output logic [CNT_W-1:0]           count_o,
  output logic [NUM_OPGROUPS-1:0]    group_busy_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    fpu_req_t               req;
    logic [3*FLEN-1:0]      operands;
    logic [TAG_WIDTH-1:0]   tag;
  } entry_t;

  entry_t                  mem_q [DEPTH];
  entry_t                  mem_d [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_W-1:0]        grp_cnt_q [NUM_OPGROUPS];
  logic [CNT_W-1:0]        grp_cnt_d [NUM_OPGROUPS];
  logic [NUM_OPGROUPS-1:0] group_busy_q, group_busy_d;

  entry_t                  in_entry;
  entry_t                  head;
  logic                    full, empty, bypass;
  logic                    push, pop, wr_en, rd_en;
  logic [NUM_OPGROUPS-1:0] in_grp_oh, head_grp_oh;

  function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pack the incoming request and classify it once, at the point of entry.
  always_comb begin
    in_entry                 = '0;
    in_entry.req.illegal     = req_illegal(in_op_i, in_src_fmt_i, in_dst_fmt_i, FP_FMT_MASK);
    in_entry.req.op          = in_op_i;
    in_entry.req.op_mod      = in_op_mod_i;
    in_entry.req.src_fmt     = in_src_fmt_i;
    in_entry.req.dst_fmt     = in_dst_fmt_i;
    in_entry.req.int_fmt     = in_int_fmt_i;
    in_entry.req.rnd         = in_rnd_i;
    in_entry.operands        = in_operands_i;
    in_entry.tag             = in_tag_i;
  end

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign bypass = FALL_THROUGH && empty;

  assign in_ready_o  = !full && !flush_i;
  assign out_valid_o = bypass ? (in_valid_i && !flush_i) : !empty;
  assign head        = bypass ? in_entry : mem_q[rd_ptr_q];

  assign push  = in_valid_i && in_ready_o;
  assign pop   = out_valid_o && out_ready_i;
  // A bypassed request that is taken immediately never touches storage.
  assign wr_en = push && !(bypass && pop);
  assign rd_en = pop && !bypass;

  assign in_grp_oh   = NUM_OPGROUPS'(1) << get_opgroup(operation_e'(in_op_i));
  assign head_grp_oh = NUM_OPGROUPS'(1) << get_opgroup(operation_e'(mem_q[rd_ptr_q].req.op));

  assign out_op_o       = head.req.op;
  assign out_op_mod_o   = head.req.op_mod;
  assign out_src_fmt_o  = head.req.src_fmt;
  assign out_dst_fmt_o  = head.req.dst_fmt;
  assign out_int_fmt_o  = head.req.int_fmt;
  assign out_rnd_o      = head.req.rnd;
  assign out_operands_o = head.operands;
  assign out_tag_o      = head.tag;
  assign out_illegal_o  = out_valid_o && head.req.illegal;
  assign count_o        = count_q;
  assign group_busy_o   = group_busy_q;

  // Next-state for storage, pointers, occupancy and per-group counters; flush wins.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (rd_en) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    for (int g = 0; g < NUM_OPGROUPS; g++) begin
      grp_cnt_d[g] = grp_cnt_q[g] + CNT_W'(wr_en && in_grp_oh[g])
                                  - CNT_W'(rd_en && head_grp_oh[g]);
    end
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      for (int g = 0; g < NUM_OPGROUPS; g++) grp_cnt_d[g] = '0;
    end
    for (int g = 0; g < NUM_OPGROUPS; g++) group_busy_d[g] = (grp_cnt_d[g] != '0);
  end

  // State registers; payload storage needs no reset since it is gated by count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      group_busy_q <= '0;
      for (int g = 0; g < NUM_OPGROUPS; g++) grp_cnt_q[g] <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      group_busy_q <= group_busy_d;
      for (int g = 0; g < NUM_OPGROUPS; g++) grp_cnt_q[g] <= grp_cnt_d[g];
    end
  end

endmodule

// File: tb/tb_cv32e40p_fpu_req_queue.sv
// tb/tb_cv32e40p_fpu_req_queue.sv - checks three queue configurations against a FIFO model
module tb_cv32e40p_fpu_req_queue;
  import cv32e40p_fpu_pkg::*;

  typedef struct packed {
    logic [3:0]  op;
    logic        mod;
    logic [2:0]  src;
    logic [2:0]  dst;
    logic [1:0]  ifmt;
    logic [2:0]  rnd;
    logic [95:0] opnds;
    logic [4:0]  tag;
  } pay_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready, in_mod;
  logic [3:0]  in_op;
  logic [2:0]  in_src, in_dst, in_rnd;
  logic [1:0]  in_int;
  logic [95:0] in_opnds;
  logic [4:0]  in_tag;

  logic        in_ready_v [3];
  logic        out_valid_v [3];
  logic        out_ill_v [3];
  logic [3:0]  out_op_v [3];
  logic        out_mod_v [3];
  logic [2:0]  out_src_v [3];
  logic [2:0]  out_dst_v [3];
  logic [1:0]  out_int_v [3];
  logic [2:0]  out_rnd_v [3];
  logic [95:0] out_opnds_v [3];
  logic [4:0]  out_tag_v [3];
  logic [3:0]  gb_v [3];
  logic [2:0]  cnt_v [3];
  logic [1:0]  cnt2;
  pay_t        in_pay;
  pay_t        out_pay [3];

  assign cnt_v[2] = {1'b0, cnt2};
  assign in_pay   = {in_op, in_mod, in_src, in_dst, in_int, in_rnd, in_opnds, in_tag};
  for (genvar i = 0; i < 3; i++) begin : g_pay
    assign out_pay[i] = {out_op_v[i], out_mod_v[i], out_src_v[i], out_dst_v[i], out_int_v[i],
                         out_rnd_v[i], out_opnds_v[i], out_tag_v[i]};
  end

  cv32e40p_fpu_req_queue #(.DEPTH(4), .FALL_THROUGH(1'b0)) u_dut (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_v[0]),
    .in_op_i(in_op), .in_op_mod_i(in_mod), .in_src_fmt_i(in_src), .in_dst_fmt_i(in_dst),
    .in_int_fmt_i(in_int), .in_rnd_i(in_rnd), .in_operands_i(in_opnds), .in_tag_i(in_tag),
    .out_valid_o(out_valid_v[0]), .out_ready_i(out_ready), .out_op_o(out_op_v[0]),
    .out_op_mod_o(out_mod_v[0]), .out_src_fmt_o(out_src_v[0]), .out_dst_fmt_o(out_dst_v[0]),
    .out_int_fmt_o(out_int_v[0]), .out_rnd_o(out_rnd_v[0]), .out_operands_o(out_opnds_v[0]),
    .out_tag_o(out_tag_v[0]), .out_illegal_o(out_ill_v[0]), .count_o(cnt_v[0]),
    .group_busy_o(gb_v[0]));

  cv32e40p_fpu_req_queue #(.DEPTH(4), .FALL_THROUGH(1'b1)) u_ft (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_v[1]),
    .in_op_i(in_op), .in_op_mod_i(in_mod), .in_src_fmt_i(in_src), .in_dst_fmt_i(in_dst),
    .in_int_fmt_i(in_int), .in_rnd_i(in_rnd), .in_operands_i(in_opnds), .in_tag_i(in_tag),
    .out_valid_o(out_valid_v[1]), .out_ready_i(out_ready), .out_op_o(out_op_v[1]),
    .out_op_mod_o(out_mod_v[1]), .out_src_fmt_o(out_src_v[1]), .out_dst_fmt_o(out_dst_v[1]),
    .out_int_fmt_o(out_int_v[1]), .out_rnd_o(out_rnd_v[1]), .out_operands_o(out_opnds_v[1]),
    .out_tag_o(out_tag_v[1]), .out_illegal_o(out_ill_v[1]), .count_o(cnt_v[1]),
    .group_busy_o(gb_v[1]));

  cv32e40p_fpu_req_queue #(.DEPTH(3), .FALL_THROUGH(1'b0)) u_d3 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_v[2]),
    .in_op_i(in_op), .in_op_mod_i(in_mod), .in_src_fmt_i(in_src), .in_dst_fmt_i(in_dst),
    .in_int_fmt_i(in_int), .in_rnd_i(in_rnd), .in_operands_i(in_opnds), .in_tag_i(in_tag),
    .out_valid_o(out_valid_v[2]), .out_ready_i(out_ready), .out_op_o(out_op_v[2]),
    .out_op_mod_o(out_mod_v[2]), .out_src_fmt_o(out_src_v[2]), .out_dst_fmt_o(out_dst_v[2]),
    .out_int_fmt_o(out_int_v[2]), .out_rnd_o(out_rnd_v[2]), .out_operands_o(out_opnds_v[2]),
    .out_tag_o(out_tag_v[2]), .out_illegal_o(out_ill_v[2]), .count_o(cnt2),
    .group_busy_o(gb_v[2]));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model: one plain FIFO per instance ----------------
  pay_t m_q [3][8];
  int   m_hd [3];
  int   m_n [3];

  function automatic int dep(int i);
    return (i == 2) ? 3 : 4;
  endfunction

  function automatic bit ft(int i);
    return i == 1;
  endfunction

  function automatic int grp_of(logic [3:0] op);
    if (op <= 3) return 0;
    if (op <= 5) return 1;
    if (op <= 9) return 2;
    return 3;
  endfunction

  function automatic logic ill_of(pay_t p);
    logic [4:0] mask;
    mask = 5'b00001;
    return (p.op > 4'd14) || (((mask >> p.src) & 5'd1) == 5'd0) || (((mask >> p.dst) & 5'd1) == 5'd0);
  endfunction

  bit         mb_byp, mb_ev, mb_push, mb_pop;
  pay_t       mb_head;
  logic [3:0] mb_gb;

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_hd[i] = 0;
      m_n[i]  = 0;
    end
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 3; i++) begin
          m_hd[i] = 0;
          m_n[i]  = 0;
        end
      end else begin
        for (int i = 0; i < 3; i++) begin
          mb_byp = ft(i) && (m_n[i] == 0) && in_valid && !flush;
          mb_ev  = (m_n[i] > 0) || mb_byp;
          chk($sformatf("in_ready[%0d]", i), in_ready_v[i], (m_n[i] < dep(i)) && !flush);
          chk($sformatf("out_valid[%0d]", i), out_valid_v[i], mb_ev);
          chk($sformatf("count[%0d]", i), cnt_v[i], m_n[i]);
          mb_gb = '0;
          for (int k = 0; k < m_n[i]; k++) mb_gb[grp_of(m_q[i][(m_hd[i] + k) % 8].op)] = 1'b1;
          chk($sformatf("group_busy[%0d]", i), gb_v[i], mb_gb);
          if (mb_ev && out_valid_v[i]) begin
            mb_head = mb_byp ? in_pay : m_q[i][m_hd[i]];
            chk($sformatf("payload[%0d]", i), out_pay[i], mb_head);
            chk($sformatf("illegal[%0d]", i), out_ill_v[i], ill_of(mb_head));
          end
          // advance the model across the coming clock edge
          if (flush) begin
            m_hd[i] = 0;
            m_n[i]  = 0;
          end else begin
            mb_push = in_valid && (m_n[i] < dep(i));
            mb_pop  = mb_ev && out_ready;
            if (!(mb_byp && mb_pop)) begin
              if (mb_pop) begin
                m_hd[i] = (m_hd[i] + 1) % 8;
                m_n[i]  = m_n[i] - 1;
              end
              if (mb_push) begin
                m_q[i][(m_hd[i] + m_n[i]) % 8] = in_pay;
                m_n[i] = m_n[i] + 1;
              end
            end
          end
        end
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] op, input logic [2:0] src, input logic [2:0] dst,
                         input logic [4:0] tag);
    in_op    = op;
    in_src   = src;
    in_dst   = dst;
    in_tag   = tag;
    in_mod   = tag[0];
    in_int   = tag[1:0];
    in_rnd   = tag[2:0];
    in_opnds = {32'h3F80_0000 + 32'(tag), 32'h4000_0000 ^ 32'(tag), 32'hC0DE_0000 | 32'(tag)};
  endtask

  int   nxt, ngot, cyc;
  logic [4:0] got [16];

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(4'd2, 3'd0, 3'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset count", cnt_v[0], 0);
    chk("reset in_ready", in_ready_v[0], 1);
    chk("reset out_valid", out_valid_v[0], 0);
    chk("reset group_busy", gb_v[0], 0);
    chk("reset illegal", out_ill_v[0], 0);
    step();

    // four ADDs with the output stalled
    for (int t = 0; t < 4; t++) begin
      set_req(4'd2, 3'd0, 3'd0, 5'(t));
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("fill count", cnt_v[0], 4);
    chk("fill in_ready", in_ready_v[0], 0);
    chk("fill group_busy", gb_v[0], 4'b0001);
    chk("fill d3 count", cnt_v[2], 3);
    step();
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("drain tag", out_tag_v[0], t);
      step();
    end
    @(negedge clk);
    chk("drain count", cnt_v[0], 0);
    step();

    // legality: FP64 source, then legal MUL, then undefined op
    out_ready = 1'b0;
    set_req(4'd2, 3'd1, 3'd0, 5'd5); in_valid = 1'b1; step();
    set_req(4'd3, 3'd0, 3'd0, 5'd6); step();
    set_req(4'd15, 3'd0, 3'd0, 5'd7); step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("illegal groups", gb_v[0], 4'b1001);
    step();
    out_ready = 1'b1;
    @(negedge clk); chk("ill fp64 tag", out_tag_v[0], 5); chk("ill fp64", out_ill_v[0], 1); step();
    @(negedge clk); chk("legal mul", out_ill_v[0], 0); step();
    @(negedge clk); chk("ill op", out_ill_v[0], 1); step();

    // alternating DIV / F2I at steady count 2
    out_ready = 1'b0;
    set_req(4'd4, 3'd0, 3'd0, 5'd8); in_valid = 1'b1; step();
    set_req(4'd11, 3'd0, 3'd0, 5'd9); step();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_req((k % 2) ? 4'd11 : 4'd4, 3'd0, 3'd0, 5'(10 + k));
      @(negedge clk);
      chk("steady group_busy", gb_v[0], 4'b1010);
      chk("steady count", cnt_v[0], 2);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();

    // fall-through on an empty queue
    set_req(4'd2, 3'd0, 3'd0, 5'd20); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("ft valid", out_valid_v[1], 1);
    chk("ft tag", out_tag_v[1], 20);
    chk("ft count", cnt_v[1], 0);
    chk("noft valid", out_valid_v[0], 0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("ft count after", cnt_v[1], 0);
    chk("noft tag after", out_tag_v[0], 20);
    step();
    step();

    // flush with three queued and a concurrent request
    out_ready = 1'b0;
    for (int t = 21; t < 24; t++) begin
      set_req(4'd5, 3'd0, 3'd0, 5'(t)); in_valid = 1'b1; step();
    end
    set_req(4'd5, 3'd0, 3'd0, 5'd24); flush = 1'b1;
    @(negedge clk);
    chk("flush in_ready", in_ready_v[0], 0);
    chk("flush pre count", cnt_v[0], 3);
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush count", cnt_v[0], 0);
    chk("flush valid", out_valid_v[0], 0);
    chk("flush group_busy", gb_v[0], 0);
    step();

    // DEPTH=3 wrap: tags 0..9 in order
    nxt = 0; ngot = 0; cyc = 0;
    while ((nxt < 10 || ngot < 10) && cyc < 80) begin
      in_valid  = (nxt < 10);
      set_req(4'd2, 3'd0, 3'd0, 5'(nxt));
      out_ready = (cyc < 12) ? ((cyc % 4) == 3) : 1'b1;
      @(negedge clk);
      if (out_valid_v[2] && out_ready && ngot < 16) begin
        got[ngot] = out_tag_v[2];
        ngot++;
      end
      if (in_valid && in_ready_v[2]) nxt++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("d3 issued", ngot, 10);
    for (int k = 0; k < 10; k++) chk($sformatf("d3 order %0d", k), got[k], k);
    out_ready = 1'b1;
    repeat (8) step();

    // reset mid-operation
    out_ready = 1'b0;
    set_req(4'd6, 3'd0, 3'd0, 5'd1); in_valid = 1'b1; step();
    set_req(4'd6, 3'd0, 3'd0, 5'd2); step();
    in_valid = 1'b0; rst = 1'b1; step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst count", cnt_v[0], 0);
    chk("rst valid", out_valid_v[0], 0);
    chk("rst group_busy", gb_v[0], 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cv32e40p_fpu_req_queue.md
Name: cv32e40p_fpu_req_queue

Overview:
Parametrised, tagged request buffer between the APU dispatch path and the FPNEW instance.
- Accepts FP requests (operation, modifier, formats, rounding mode, operands, tag) on a valid/ready input.
- Holds up to DEPTH requests and issues them in order on a valid/ready output.
- Per-entry legality check against the enabled formats; per-operation-group occupancy tracking for hazard logic.
- Supports an optional fall-through mode and a synchronous flush.

Parameters:
DEPTH, 4, number of entries (>=1; need not be a power of two)
FLEN, 32, operand width in bits
TAG_WIDTH, 5, request tag width
FP_FMT_MASK, 5'b00001, bit i set = fp_format_e value i is enabled
FALL_THROUGH, 0, 1 = empty-queue request is visible at the output in the same cycle

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush_i  in  1  discard all entries
in_valid_i  in  1  request valid
in_ready_o  out  1  queue can accept
in_op_i  in  OP_BITS  operation_e
in_op_mod_i  in  1  operation modifier
in_src_fmt_i  in  FP_FORMAT_BITS  source format
in_dst_fmt_i  in  FP_FORMAT_BITS  destination format
in_int_fmt_i  in  INT_FORMAT_BITS  integer format
in_rnd_i  in  3  rounding mode
in_operands_i  in  3*FLEN  operands a,b,c
in_tag_i  in  TAG_WIDTH  request tag
out_valid_o  out  1  head valid
out_ready_i  in  1  FPU accepts head
out_op_o, out_op_mod_o, out_src_fmt_o, out_dst_fmt_o, out_int_fmt_o, out_rnd_o, out_operands_o, out_tag_o  out  (as inputs)  head fields
out_illegal_o  out  1  head request failed legality check
count_o  out  $clog2(DEPTH+1)  occupancy
group_busy_o  out  NUM_OPGROUPS  bit g set = at least one queued entry of group g

Interface: one clock (clk). Reset (rst) is synchronous and active-high.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Pointers and count = 0; all group counters = 0.
  - Outputs: out_valid_o=0, in_ready_o=1, count_o=0, group_busy_o=0, out_illegal_o=0.
  - Payload outputs are don't-care while out_valid_o=0.
- Push:
  - push = in_valid_i & in_ready_o.
  - in_ready_o = !full & !flush_i. No push into a full queue, even when a pop occurs in the same cycle.
- Pop:
  - pop = out_valid_o & out_ready_i.
  - Head fields are stable while out_valid_o=1 and out_ready_i=0.
- Latency:
  - FALL_THROUGH=0: a pushed entry appears at the output the cycle after the push.
  - FALL_THROUGH=1 with an empty queue: out_valid_o = in_valid_i & !flush_i, and the head fields are the input fields. If popped in the same cycle, the request is not stored and count stays 0.
- Legality, computed at push and stored per entry:
  - illegal = (op > CPKCD) | (src_fmt >= NUM_FP_FORMATS) | (dst_fmt >= NUM_FP_FORMATS) | !FP_FMT_MASK[src_fmt] | !FP_FMT_MASK[dst_fmt].
  - Illegal entries are queued and issued in order with out_illegal_o=1. The downstream block raises the exception.
- Pointers:
  - Read and write pointers wrap from DEPTH-1 to 0.
  - count_o += push - pop.
  - Full when count==DEPTH; empty when count==0.
- Group counters:
  - One counter per opgroup, width $clog2(DEPTH+1).
  - Increment on push of that group; decrement on pop of that group.
  - Push and pop of the same group in the same cycle leaves the counter unchanged.
  - Illegal entries count toward group get_opgroup(op), and toward CONV if op > CPKCD.
  - group_busy_o[g] = counter[g] != 0. It is registered and excludes a fall-through bypass.
- Flush:
  - Next cycle: count=0, pointers=0, all group counters=0, out_valid_o=0.
  - Flush overrides any push or pop in the same cycle. A pop handshake that completes in the flush cycle is still considered taken by the FPU.
- Reset asserted mid-operation discards all entries identically to flush.

Decomposition:
Additions to cv32e40p_fpu_pkg:
- opgroup_e {ADDMUL, DIVSQRT, NONCOMP, CONV}, NUM_OPGROUPS=4.
- roundmode_e {RNE, RTZ, RDN, RUP, RMM, DYN=3'b111}.
- Function get_opgroup(operation_e): FMADD..MUL -> ADDMUL, DIV/SQRT -> DIVSQRT, SGNJ..CLASSIFY -> NONCOMP, F2F..CPKCD -> CONV.
- Packed struct fpu_req_t holding all payload fields plus the illegal bit.

Storage, pointers and counters live inline; no sub-module is needed.

Test Plan:
- Reset, then push 4 legal ADD requests with tags 0..3 and out_ready_i=0 -> count_o=4, in_ready_o=0, group_busy_o=4'b0001. Then set out_ready_i=1 -> tags 0,1,2,3 issue on consecutive cycles and count_o returns to 0.
- Push with in_src_fmt_i=FP64 while FP_FMT_MASK=5'b00001 -> out_illegal_o=1 at issue. A following FP32 MUL issues next with out_illegal_o=0.
- Alternating DIV and F2I pushes with simultaneous pops at steady count 2 -> group_busy_o stays 4'b1010 and the counters are never negative.
- FALL_THROUGH=1, empty queue, in_valid_i=1, out_ready_i=1 -> out_valid_o=1 in the same cycle with out_tag_o=in_tag_i, and count_o stays 0.
- With 3 entries queued, assert flush_i together with in_valid_i=1 -> in_ready_o=0, and next cycle count_o=0, out_valid_o=0, group_busy_o=0.
- DEPTH=3: push and pop 10 requests with tags 0..9 -> pointers wrap correctly and the output tag order is 0..9.
